// File: rtl/immenc.sv
// RV32I instruction encoder: the inverse of the immediate generator.
// Range-checks the immediate and verifies the opcode. Scatters the immediate
// bits into the RV32I field positions through a two-stage valid/ready pipeline.
// Optional macro IMMENC_STATS_EN adds saturating encode/error counters.
module immenc #(
  parameter logic [31:0] ERR_WORD     = 32'h00000013,
  parameter bit          CHECK_OPCODE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o
`ifdef IMMENC_STATS_EN
  ,
  output logic [15:0] enc_cnt_o,
  output logic [15:0] err_cnt_o
`endif
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // The immediate must be representable in the format's signed field and
  // respect the 2-byte alignment of branch/jump targets.
  function automatic logic imm_range_err(input logic [2:0] fmt, input logic signed [31:0] imm);
    logic e;
    e = 1'b0;
    case (fmt)
      FMT_R:        e = 1'b0;
      FMT_I, FMT_S: e = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        e = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        e = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        e = |imm[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  // Only the major opcodes that actually use a format are accepted with it.
  function automatic logic opcode_err(input logic [2:0] fmt, input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_R:   ok = (op == 7'b0110011);
      FMT_I:   ok = (op == 7'b0000011) || (op == 7'b0010011) || (op == 7'b1100111);
      FMT_S:   ok = (op == 7'b0100011);
      FMT_B:   ok = (op == 7'b1100011);
      FMT_U:   ok = (op == 7'b0110111) || (op == 7'b0010111);
      FMT_J:   ok = (op == 7'b1101111);
      default: ok = 1'b0;
    endcase
    return !ok;
  endfunction

  // Field image of the instruction word for each format.
  function automatic logic [31:0] pack_word(
    input logic [2:0]         fmt,
    input logic [6:0]         op,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   w = {imm[31:12], rd, op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        vld_p1;
  logic        err_p1;
  logic [31:0] img_p1;
  logic        vld_p2;
  logic        err_p2;
  logic [31:0] instr_p2;
  logic        s1_adv;
  logic        s2_adv;
  logic        err_p0;

  assign s2_adv     = !vld_p2 || out_ready_i;
  assign s1_adv     = !vld_p1 || s2_adv;
  assign in_ready_o = s1_adv;
  assign err_p0     = imm_range_err(fmt_i, imm_i) ||
                      (CHECK_OPCODE && opcode_err(fmt_i, opcode_i));

  // ---- stage 1: capture request, range/opcode check, field image ----
  // Stage-1 occupancy; loads the request valid whenever the stage can advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid_i;
  end

  // Stage-1 data is only written on an accepted request.
  always_ff @(posedge clk_i) begin
    if (s1_adv && in_valid_i) begin
      err_p1 <= err_p0;
      img_p1 <= pack_word(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
    end
  end

  // ---- stage 2: final word (error substitution) driving the outputs ----
  // Output register; holds while the consumer stalls, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      instr_p2 <= 32'h0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        err_p2   <= err_p1;
        instr_p2 <= err_p1 ? ERR_WORD : img_p1;
      end
    end
  end

  assign out_valid_o = vld_p2;
  assign instr_o     = instr_p2;
  assign err_o       = err_p2;

`ifdef IMMENC_STATS_EN
  // Count every output handshake, and separately those carrying an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enc_cnt_o <= 16'h0;
      err_cnt_o <= 16'h0;
    end else if (vld_p2 && out_ready_i) begin
      enc_cnt_o <= sat_inc(enc_cnt_o);
      if (err_p2) err_cnt_o <= sat_inc(err_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_immenc.sv
// Directed testbench for immenc: per-format encodings, range/opcode errors,
// latency, backpressure ordering and asynchronous reset with data in flight.
module tb_immenc;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic        err_o;
`ifdef IMMENC_STATS_EN
  logic [15:0] enc_cnt_o;
  logic [15:0] err_cnt_o;
  int          n_enc_exp = 0;
  int          n_err_exp = 0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  immenc dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fmt_i       (fmt_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .instr_o     (instr_o),
    .err_o       (err_o)
`ifdef IMMENC_STATS_EN
    ,
    .enc_cnt_o   (enc_cnt_o),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Call at a falling edge; one request, checks 2-cycle latency and result.
  task automatic run_one(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_instr, input logic exp_err);
    fmt_i = fmt; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk({tag, "_inrdy"}, {31'h0, in_ready_o}, 32'h1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk({tag, "_vld_c1"}, {31'h0, out_valid_o}, 32'h0);
    @(negedge clk_i);
    #1;
    chk({tag, "_vld_c2"}, {31'h0, out_valid_o}, 32'h1);
    chk({tag, "_instr"}, instr_o, exp_instr);
    chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
`ifdef IMMENC_STATS_EN
    n_enc_exp++;
    if (exp_err) n_err_exp++;
`endif
    @(negedge clk_i);
  endtask

  logic [31:0] str_imm   [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
  logic [4:0]  str_rd    [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
  logic [31:0] str_instr [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

  initial begin
    int sent;
    int rcv;
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    fmt_i = 3'd0; opcode_i = 7'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    funct3_i = 3'd0; funct7_i = 7'd0; imm_i = 32'd0;
    #1;
    chk("rst_vld",   {31'h0, out_valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_err",   {31'h0, err_o}, 32'h0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_inrdy", {31'h0, in_ready_o}, 32'h1);
    @(negedge clk_i);

    //       tag       fmt   opcode      rd  rs1 rs2 f3 f7          imm            instr         err
    run_one("I_neg",   3'd1, 7'b0010011, 5, 6, 0, 0, 7'd0,        32'hFFFFF800, 32'h80030293, 1'b0);
    run_one("I_max",   3'd1, 7'b0010011, 5, 6, 0, 0, 7'd0,        32'h000007FF, 32'h7FF30293, 1'b0);
    run_one("I_ovf",   3'd1, 7'b0010011, 5, 6, 0, 0, 7'd0,        32'h00000800, 32'h00000013, 1'b1);
    run_one("B_ok",    3'd3, 7'b1100011, 0, 1, 2, 0, 7'd0,        32'h00000010, 32'h00208863, 1'b0);
    run_one("B_odd",   3'd3, 7'b1100011, 0, 1, 2, 0, 7'd0,        32'h00000011, 32'h00000013, 1'b1);
    run_one("J_ovf",   3'd5, 7'b1101111, 1, 0, 0, 0, 7'd0,        32'h00100000, 32'h00000013, 1'b1);
    run_one("J_ok",    3'd5, 7'b1101111, 1, 0, 0, 0, 7'd0,        32'h00000800, 32'h001000EF, 1'b0);
    run_one("S_neg",   3'd2, 7'b0100011, 0, 2, 3, 2, 7'd0,        32'hFFFFFFFC, 32'hFE312E23, 1'b0);
    run_one("U_ok",    3'd4, 7'b0110111, 10, 0, 0, 0, 7'd0,       32'h12345000, 32'h12345537, 1'b0);
    run_one("U_low",   3'd4, 7'b0110111, 10, 0, 0, 0, 7'd0,       32'h12345001, 32'h00000013, 1'b1);
    run_one("R_sub",   3'd0, 7'b0110011, 1, 2, 3, 0, 7'b0100000,  32'hDEADBEEF, 32'h403100B3, 1'b0);
    run_one("op_bad",  3'd1, 7'b0110011, 1, 2, 0, 0, 7'd0,        32'h00000000, 32'h00000013, 1'b1);
    run_one("fmt6",    3'd6, 7'b0000000, 0, 0, 0, 0, 7'd0,        32'h00000000, 32'h00000013, 1'b1);

`ifdef IMMENC_STATS_EN
    chk("stat_enc", {16'h0, enc_cnt_o}, n_enc_exp);
    chk("stat_err", {16'h0, err_cnt_o}, n_err_exp);
`endif

    // Backpressure: 4 I-type requests, consumer stalled for 3 cycles.
    sent = 0; rcv = 0;
    fmt_i = 3'd1; opcode_i = 7'b0010011; rs1_i = 5'd0; rs2_i = 5'd0;
    funct3_i = 3'd0; funct7_i = 7'd0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      out_ready_i = (cyc >= 5);
      if (sent < 4) begin
        in_valid_i = 1'b1; imm_i = str_imm[sent]; rd_i = str_rd[sent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("bp_inrdy_%0d", cyc), {31'h0, in_ready_o}, 32'h0);
        chk($sformatf("bp_vld_%0d", cyc), {31'h0, out_valid_o}, 32'h1);
        chk($sformatf("bp_hold_%0d", cyc), instr_o, str_instr[0]);
      end
      if (out_valid_o && out_ready_i) begin
        chk($sformatf("bp_word_%0d", rcv), instr_o, str_instr[rcv]);
        rcv++;
      end
      if (in_valid_i && in_ready_o) sent++;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    chk("bp_sent", sent, 32'd4);
    chk("bp_rcv", rcv, 32'd4);
    @(negedge clk_i);
    #1;
    chk("bp_empty", {31'h0, out_valid_o}, 32'h0);

    // Reset with two entries in flight (consumer stalled).
    @(negedge clk_i);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; imm_i = str_imm[0]; rd_i = str_rd[0];
    @(negedge clk_i);
    imm_i = str_imm[1]; rd_i = str_rd[1];
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("rf_vld_pre", {31'h0, out_valid_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rf_vld",   {31'h0, out_valid_o}, 32'h0);
    chk("rf_instr", instr_o, 32'h0);
    chk("rf_err",   {31'h0, err_o}, 32'h0);
`ifdef IMMENC_STATS_EN
    chk("rf_enc_cnt", {16'h0, enc_cnt_o}, 32'h0);
    chk("rf_err_cnt", {16'h0, err_cnt_o}, 32'h0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rf_stale_%0d", k), {31'h0, out_valid_o}, 32'h0);
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
